ps2_scan_fifo: RTL
==================

// Module: ps2_scan_fifo
// PURPOSE
//  Next-gen PS/2 keyboard receiver: oversamples ps2_clk/data in the clk domain and deframes 11-bit frames.
//  Checks start, odd parity and stop bits. Folds E0/F0 prefixes into make/break/extended flags.
//  Queues decoded key events in a DEPTH-entry FIFO read through a valid/ready handshake.
//  Sits between the PS/2 pins and the text/line-editing logic. A watchdog recovers from partial frames.
// PARAMETERS
//  DEPTH        8     FIFO entries; power of two, >= 2
//  SYNC_STAGES  2     synchroniser flops on ps2_clk and data; >= 2
//  TIMEOUT      2000  clk cycles without a ps2_clk falling edge before a partial frame is aborted
// PORTS
//  clk         in   1   system clock; must be >= 8x the ps2_clk rate
//  rst         in   1   asynchronous, active-high reset
//  ps2_clk     in   1   PS/2 clock from the keyboard (asynchronous)
//  data        in   1   PS/2 data from the keyboard (asynchronous)
//  rx_code     out  8   head-of-FIFO scan code
//  rx_brk      out  1   head entry is a break (preceded by F0)
//  rx_ext      out  1   head entry is extended (preceded by E0)
//  rx_valid    out  1   FIFO non-empty; head fields valid
//  rx_ready    in   1   consumer pops the head when rx_valid && rx_ready at a clk edge
//  fill_level  out  $clog2(DEPTH+1)  number of stored entries
//  busy        out  1   frame reception in progress (FSM not IDLE)
//  parity_err  out  1   1-cycle pulse: frame dropped on parity failure
//  frame_err   out  1   1-cycle pulse: frame dropped on bad start/stop bit or timeout
//  overflow    out  1   1-cycle pulse: decoded event dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0. FIFO emptied, FSM in IDLE, prefix flags cleared. Applies immediately, also mid-frame.
//  Input sync: SYNC_STAGES flops on each input. Falling edge (fe) = previous synchronised ps2_clk 1, current 0.
//   All sampling of data happens on fe cycles only.
//  FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
//   IDLE: on fe, data==0 -> DATA with bit counter=0. Data==1 on fe -> frame_err, stay IDLE.
//   DATA: on fe, shift data into bit[cnt], LSB first. After cnt==7 -> PARITY.
//   PARITY: on fe, store parity bit -> STOP.
//   STOP: on fe, check stop==1 and odd parity over 8 data bits + parity bit -> decode, then IDLE.
//  Watchdog: counter cleared on every fe, counts in any state except IDLE.
//   Reaching TIMEOUT -> frame_err pulse, byte dropped, prefix flags cleared, back to IDLE.
//  Errors at STOP: stop==0 -> frame_err. Parity bad -> parity_err. Both bad -> frame_err only.
//   Any error also clears the prefix flags.
//  Decode of a good byte, in the cycle after the STOP fe:
//   0xE0 -> set ext_pend, no push.
//   0xF0 -> set brk_pend, no push.
//   Any other byte -> push {ext_pend, brk_pend, byte}, then clear both flags.
//   Prefix order is free: E0 F0 xx and F0 E0 xx give the same entry.
//  Latency: entry written at the clk edge one cycle after the STOP fe. rx_valid is high from that edge.
//  FIFO: first-word-fall-through with registered pointers (log2(DEPTH)+1 bits, wrap-around).
//   Full = fill_level==DEPTH. Empty = fill_level==0.
//  Push when full and no pop: entry dropped, overflow pulse, contents unchanged.
//  Push and pop in the same cycle: both happen, including when full or when fill==1.
//   fill_level is then unchanged and no overflow.
//  Pop when empty: ignored; pointers do not move.
//  busy=1 from the start-bit fe until return to IDLE.
// TESTING
//  Make code: frame 0x75 (bits 1,0,1,0,1,1,1,0, parity 0, stop 1) -> one entry {ext=0,brk=0,code=0x75};
//   rx_valid 1 cycle after the STOP fe; fill_level=1.
//  Break code: frames F0, 75 -> exactly one entry {0,1,0x75}; no entry for F0. Then E0,F0,75 -> {1,1,0x75}.
//  Parity: 0x75 sent with parity 1 -> parity_err pulse, no push.
//   A pending F0 is cleared, so the next 0x75 yields {0,0,0x75}.
//  Timeout/reset: stop ps2_clk after 4 bits -> frame_err after TIMEOUT cycles, busy=0.
//   Next full frame decodes correctly. A separate run asserts rst mid-frame: outputs 0 at once.
//  Overflow: send DEPTH+1 codes with rx_ready=0 -> fill_level=DEPTH, one overflow pulse, oldest DEPTH kept.
//   Then pop while a push lands -> fill_level stays DEPTH, no overflow.
//  Drain order: 3 codes 0x1C,0x32,0x21 with rx_ready=1 -> popped in order; rx_valid drops with fill_level=0.

Source files
------------

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver: synchronises ps2_clk/data, deframes 11-bit frames, folds E0/F0
// prefixes into flags and queues key events in a first-word-fall-through FIFO.
module ps2_scan_fifo #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 2000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ps2_clk,
  input  logic                         data,
  output logic [7:0]                   rx_code,
  output logic                         rx_brk,
  output logic                         rx_ext,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         busy,
  output logic                         parity_err,
  output logic                         frame_err,
  output logic                         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] ck_sync_q, ck_sync_d, dt_sync_q, dt_sync_d;
  logic                   ck_prev_q, ck_prev_d;
  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             sh_q, sh_d;
  logic                   par_q, par_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic                   ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic                   dec_vld_q, dec_vld_d;
  logic [7:0]             dec_byte_q, dec_byte_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic [AW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [9:0]             mem [DEPTH];

  logic       fe, din, push, pop, full, do_push;
  logic [AW:0] fill;

  assign fe  = ck_prev_q & ~ck_sync_q[SYNC_STAGES-1];
  assign din = dt_sync_q[SYNC_STAGES-1];

  assign fill    = wptr_q - rptr_q;
  assign full    = (fill == (AW+1)'(DEPTH));
  assign push    = dec_vld_q && (dec_byte_q != 8'hE0) && (dec_byte_q != 8'hF0);
  assign pop     = rx_valid && rx_ready;
  assign do_push = push && (!full || pop);

  always_comb begin
    ck_sync_d  = {ck_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dt_sync_d  = {dt_sync_q[SYNC_STAGES-2:0], data};
    ck_prev_d  = ck_sync_q[SYNC_STAGES-1];
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    par_d      = par_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    dec_byte_d = dec_byte_q;
    dec_vld_d  = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    wd_d       = (state_q == StIdle || fe) ? '0 : wd_q + WW'(1);

    // Decode the byte accepted at the previous STOP edge
    if (dec_vld_q) begin
      if (dec_byte_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (dec_byte_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end

    if (state_q != StIdle && !fe && wd_q == WW'(TIMEOUT - 1)) begin
      state_d    = StIdle;
      ferr_d     = 1'b1;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
      wd_d       = '0;
    end else if (fe) begin
      unique case (state_q)
        StIdle: begin
          if (!din) begin
            state_d = StData;
            cnt_d   = 3'd0;
          end else begin
            ferr_d = 1'b1;
          end
        end
        StData: begin
          sh_d  = {din, sh_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = din;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!din) begin
            ferr_d     = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end else if (^{sh_q, par_q} == 1'b0) begin
            perr_d     = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end else begin
            dec_vld_d  = 1'b1;
            dec_byte_d = sh_q;
          end
        end
      endcase
    end

    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    ovf_d  = push && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_sync_q  <= '1;
      dt_sync_q  <= '1;
      ck_prev_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      dec_vld_q  <= 1'b0;
      dec_byte_q <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      ck_sync_q  <= ck_sync_d;
      dt_sync_q  <= dt_sync_d;
      ck_prev_q  <= ck_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      dec_vld_q  <= dec_vld_d;
      dec_byte_q <= dec_byte_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= {ext_pend_q, brk_pend_q, dec_byte_q};
  end

  // Head fields are forced to zero while empty so reset leaves every output at 0
  assign rx_valid = (fill != '0);
  assign {rx_ext, rx_brk, rx_code} = rx_valid ? mem[rptr_q[AW-1:0]] : 10'd0;
  assign fill_level = fill;
  assign busy       = (state_q != StIdle);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule
